// File: rtl/cadr_ddram_bridge.sv
// Bridges cadr_core 32-bit word requests onto the MiSTer DDRAM Avalon port as
// single 64-bit beats, with a one-line read buffer that serves word pairs.
module cadr_ddram_bridge #(
  parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
  parameter int unsigned ADDR_W    = 22,
  parameter bit          CACHE_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              inv,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              DDRAM_CLK,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [28:0]       DDRAM_ADDR,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  output logic              DDRAM_RD,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, DONE} state_e;

  state_e            state_q;
  logic              ack_q, rd_q, we_q, valid_q;
  logic [31:0]       rdata_q;
  logic [28:0]       ddr_addr_q;
  logic [63:0]       din_q, line_q;
  logic [7:0]        be_q;
  logic [ADDR_W-2:0] tag_q;

  logic [ADDR_W-2:0] line_idx;
  logic [28:0]       ddr_addr_d;
  logic              tag_hit;

  // addr is held stable while req is high, so it also names the pending line in RD_WAIT
  assign line_idx   = addr[ADDR_W-1:1];
  assign ddr_addr_d = BASE_ADDR + 29'(line_idx);
  assign tag_hit    = valid_q && (tag_q == line_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      ddr_addr_q <= '0;
      din_q      <= '0;
      be_q       <= '0;
      line_q     <= '0;
      tag_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (req && !ack_q) begin
          if (we) begin
            ddr_addr_q <= ddr_addr_d;
            din_q      <= {2{wdata}};
            be_q       <= addr[0] ? 8'hF0 : 8'h0F;
            we_q       <= 1'b1;
            state_q    <= WR;
            // keep the buffered line coherent with the write going out
            if (tag_hit) begin
              if (addr[0]) line_q[63:32] <= wdata;
              else         line_q[31:0]  <= wdata;
            end
          end else if (CACHE_EN && tag_hit) begin
            rdata_q <= addr[0] ? line_q[63:32] : line_q[31:0];
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            ddr_addr_q <= ddr_addr_d;
            rd_q       <= 1'b1;
            state_q    <= RD;
          end
        end
        WR: if (!DDRAM_BUSY) begin
          we_q    <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        RD: if (!DDRAM_BUSY) begin
          rd_q    <= 1'b0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: if (DDRAM_DOUT_READY) begin
          rdata_q <= addr[0] ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
          if (CACHE_EN) begin
            line_q  <= DDRAM_DOUT;
            tag_q   <= line_idx;
            valid_q <= 1'b1;
          end
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // invalidate wins over a same-cycle fill or merge
      if (inv) valid_q <= 1'b0;
    end
  end

  assign rdata          = rdata_q;
  assign ack            = ack_q;
  assign DDRAM_CLK      = clk;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;

endmodule

// File: tb/tb_cadr_ddram_bridge.sv
// Bench for cadr_ddram_bridge: a DDR slave plus a word-level memory/line model,
// driving one cached instance and one uncached instance with a wrapping base.
module tb_cadr_ddram_bridge;
  localparam logic [28:0] BASE0 = 29'h0600_0000;
  localparam logic [28:0] BASE1 = 29'h1FFF_FF00;

  logic clk = 0, reset_n = 0, we = 0, inv = 0, busy = 0, drdy = 0, req0 = 0, req1 = 0;
  logic [21:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [63:0] dout = '0;

  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, dclk0, dclk1, rd0, rd1, we0, we1;
  logic [7:0]  bc0, bc1, be0, be1;
  logic [28:0] da0, da1;
  logic [63:0] din0, din1;

  always #5 clk = ~clk;

  cadr_ddram_bridge #(.BASE_ADDR(BASE0), .ADDR_W(22), .CACHE_EN(1'b1)) u_c (
    .clk(clk), .reset_n(reset_n), .req(req0), .we(we), .addr(addr), .wdata(wdata), .inv(inv),
    .rdata(rdata0), .ack(ack0), .DDRAM_CLK(dclk0), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(bc0),
    .DDRAM_ADDR(da0), .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(drdy), .DDRAM_RD(rd0),
    .DDRAM_DIN(din0), .DDRAM_BE(be0), .DDRAM_WE(we0));

  cadr_ddram_bridge #(.BASE_ADDR(BASE1), .ADDR_W(22), .CACHE_EN(1'b0)) u_n (
    .clk(clk), .reset_n(reset_n), .req(req1), .we(we), .addr(addr), .wdata(wdata), .inv(inv),
    .rdata(rdata1), .ack(ack1), .DDRAM_CLK(dclk1), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(bc1),
    .DDRAM_ADDR(da1), .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(drdy), .DDRAM_RD(rd1),
    .DDRAM_DIN(din1), .DDRAM_BE(be1), .DDRAM_WE(we1));

  bit sel = 0;
  logic        rd_s, we_s, ack_s;
  logic [31:0] rdata_s;
  logic [28:0] da_s;
  logic [63:0] din_s;
  logic [7:0]  be_s;
  assign rd_s    = sel ? rd1 : rd0;
  assign we_s    = sel ? we1 : we0;
  assign ack_s   = sel ? ack1 : ack0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign da_s    = sel ? da1 : da0;
  assign din_s   = sel ? din1 : din0;
  assign be_s    = sel ? be1 : be0;

  int errors = 0, checks = 0;
  logic [63:0] mem [logic [20:0]];
  bit          mvalid = 0;
  logic [20:0] mtag = '0;

  task automatic pulse_inv();
    @(posedge clk); #1 inv = 1;
    @(posedge clk); #1 inv = 0;
    mvalid = 0;
  endtask

  // one request on the selected instance, with the DDR slave answering it
  task automatic xact(input bit w, input logic [21:0] a, input logic [31:0] d,
                      input int bn, input int lat, input bit inv_fill);
    logic [20:0] k;
    logic [28:0] ea;
    logic [63:0] beat;
    logic [31:0] er, ract;
    logic [7:0]  ebe;
    bit hit, got, seen_rd, fired, bad;
    int rdc, wec, bc, wc, acyc, extra;
    k = a[21:1];
    ea = (sel ? BASE1 : BASE0) + 29'(k);
    ebe = a[0] ? 8'hF0 : 8'h0F;
    if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
    hit = !w && !sel && mvalid && (mtag == k);
    beat = mem[k];
    er = a[0] ? beat[63:32] : beat[31:0];
    got = 0; seen_rd = 0; fired = 0; bad = 0;
    rdc = 0; wec = 0; bc = 0; wc = 0; acyc = 0; extra = 0; ract = '0;
    @(posedge clk); #1;
    we = w; addr = a; wdata = d;
    if (sel) req1 = 1; else req0 = 1;
    for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
      @(posedge clk); #1;
      drdy = 0; inv = 0;
      if (rd_s && we_s) bad = 1;
      if (rd_s || we_s) begin
        if (rd_s) begin rdc++; seen_rd = 1; end else wec++;
        if (da_s !== ea) bad = 1;
        if (we_s && (din_s !== {d, d} || be_s !== ebe)) bad = 1;
        busy = (bc < bn);
        if (busy) bc++;
      end else begin
        busy = 0;
        if (seen_rd && !fired) begin
          if (wc == lat) begin drdy = 1; dout = beat; inv = inv_fill; fired = 1; end
          else wc++;
        end
      end
      if (ack_s) begin got = 1; acyc = cyc; ract = rdata_s; end
    end
    req0 = 0; req1 = 0; drdy = 0; inv = 0; busy = 0;
    repeat (2) begin @(posedge clk); #1; if (ack_s) extra++; end
    checks++; if (!got) begin errors++; $display("FAIL ack_timeout a=%h: no ack within 100 cycles", a); end
    checks++; if (extra != 0) begin errors++; $display("FAIL ack_once a=%h: extra acks %0d want 0", a, extra); end
    checks++; if (rdc != ((w || hit) ? 0 : bn + 1)) begin errors++; $display("FAIL rd_cycles a=%h: got %0d want %0d", a, rdc, (w || hit) ? 0 : bn + 1); end
    checks++; if (wec != (w ? bn + 1 : 0)) begin errors++; $display("FAIL we_cycles a=%h: got %0d want %0d", a, wec, w ? bn + 1 : 0); end
    checks++; if (bad) begin errors++; $display("FAIL cmd_fields a=%h: addr/din/be wrong, want addr %h be %h", a, ea, ebe); end
    if (!w) begin
      checks++; if (ract !== er) begin errors++; $display("FAIL rdata a=%h: got %h want %h", a, ract, er); end
    end
    if (hit) begin
      checks++; if (acyc != 1) begin errors++; $display("FAIL hit_latency a=%h: got %0d want 1", a, acyc); end
    end
    if (w) begin
      if (a[0]) beat[63:32] = d; else beat[31:0] = d;
      mem[k] = beat;
    end else if (!hit && !sel) begin
      mvalid = !inv_fill; mtag = k;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({ack0, rd0, we0, ack1, rd1, we1} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {ack0, rd0, we0, ack1, rd1, we1}); end
    checks++; if ({rdata0, rdata1} !== 64'b0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
    checks++; if ({da0, da1, be0, be1} !== 74'b0) begin errors++; $display("FAIL reset_addr_be: got %h want 0", {da0, da1, be0, be1}); end
    checks++; if ({din0, din1} !== 128'b0) begin errors++; $display("FAIL reset_din: got %h want 0", {din0, din1}); end
    checks++; if (bc0 !== 8'd1 || bc1 !== 8'd1) begin errors++; $display("FAIL burstcnt: got %h/%h want 01", bc0, bc1); end
    checks++; if (dclk0 !== clk) begin errors++; $display("FAIL ddram_clk: got %b want %b", dclk0, clk); end
    @(negedge clk) reset_n = 1;
  endtask

  task automatic test_directed();
    sel = 0;
    mem[21'h1] = 64'hAAAA_BBBB_1111_2222;
    xact(0, 22'h000002, 32'h0, 0, 4, 0);
    xact(0, 22'h000003, 32'h0, 0, 0, 0);
    xact(1, 22'h000003, 32'h1234_5678, 4, 0, 0);
    xact(0, 22'h000003, 32'h0, 0, 0, 0);
    pulse_inv();
    xact(0, 22'h000002, 32'h0, 1, 2, 0);
    xact(0, 22'h000008, 32'h0, 0, 1, 1);
    xact(0, 22'h000009, 32'h0, 0, 0, 0);
  endtask

  task automatic test_stray_and_reset();
    bit seen, saw_ack, reached;
    sel = 0; seen = 0; saw_ack = 0; reached = 0;
    @(posedge clk); #1 drdy = 1; dout = {$urandom, $urandom};
    @(posedge clk); #1 drdy = 0;
    repeat (2) begin @(posedge clk); #1; if (ack0) saw_ack = 1; end
    checks++; if (saw_ack) begin errors++; $display("FAIL stray_ready: got ack want none"); end
    pulse_inv();
    @(posedge clk); #1 we = 0; addr = 22'h000002; req0 = 1;
    saw_ack = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(posedge clk); #1;
      if (ack0) saw_ack = 1;
      if (rd0) seen = 1; else if (seen) reached = 1;
    end
    checks++; if (!reached || saw_ack) begin errors++; $display("FAIL reach_rd_wait: reached %b ack %b want 1 0", reached, saw_ack); end
    reset_n = 0; #1;
    checks++; if ({ack0, rd0, we0, rdata0, da0, din0, be0} !== '0) begin
      errors++; $display("FAIL reset_mid: ack %b rd %b we %b rdata %h addr %h be %h want all 0", ack0, rd0, we0, rdata0, da0, be0);
    end
    req0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    mvalid = 0;
    xact(0, 22'h000002, 32'h0, 0, 0, 0);
  endtask

  task automatic test_uncached();
    sel = 1;
    xact(0, 22'h000002, 32'h0, 0, 1, 0);
    xact(0, 22'h000002, 32'h0, 2, 0, 0);
    xact(1, 22'h3FFFFE, 32'hCAFE_F00D, 1, 0, 0);
    xact(0, 22'h3FFFFE, 32'h0, 0, 3, 0);
    xact(0, 22'h3FFFFF, 32'h0, 0, 0, 0);
    sel = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      sel = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) pulse_inv();
      xact(1'($urandom_range(0, 1)), 22'($urandom_range(0, 7)), $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom_range(0, 7) == 0);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stray_and_reset();
    test_uncached();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
